// File: rtl/i2c_target.sv
// i2c_target: fixed-address I2C target (slave) with a byte-level user interface.
//
// The bus is oversampled on clk, which must run at least 8x faster than SCL.
// The target only ever pulls SDA low or releases it. SCL is never driven, so
// there is no clock stretching.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   scl      serial clock from the master
//   sda      serial data (open-drain: 1'b0 or 1'bz)
//   tx_data  read-byte data, captured when tx_req pulses
//   tx_req   one-cycle pulse: tx_data captured for the next read byte
//   rx_data  last byte written by the master
//   rx_valid one-cycle pulse, one cycle after rx_data updates
//   rw       R/W bit of the current transaction (1 = read)
//   busy     high from address match until STOP / START / NACK
//   stop_det one-cycle pulse on every bus STOP
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | holding SDA low for the address ACK
// WR_BYTE   | shifting in a write byte
// WR_ACK    | holding SDA low for the write-byte ACK
// RD_BYTE   | shifting a read byte out, MSB first
// RD_ACK    | sampling the master's ACK/NACK
// WAIT_STOP | not addressed, or NACKed; ignore traffic until START/STOP

module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_cond, stop_cond;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [6:0]  tx_shift;
    logic        ack_seen;
    logic        rx_load;
    logic        sda_oe;

    // Released when sda_oe is low; async reset clears sda_oe immediately.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronisers preset to 1 (idle bus level) so reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_cond = scl_s & sda_d & ~sda_s;
    assign stop_cond  = scl_s & ~sda_d & sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift_in <= 7'd0;
            tx_shift <= 7'd0;
            ack_seen <= 1'b0;
            rx_load  <= 1'b0;
            sda_oe   <= 1'b0;
            tx_req   <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            stop_det <= 1'b0;
        end else begin
            tx_req   <= 1'b0;
            stop_det <= 1'b0;
            rx_load  <= 1'b0;
            rx_valid <= rx_load;

            if (stop_cond) begin
                stop_det <= 1'b1;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                state    <= IDLE;
            end else if (start_cond) begin
                // Covers both START from IDLE and repeated START; wins over
                // an scl_rise in the same cycle.
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= ADDR;
            end else begin
                case (state)
                    IDLE: ;

                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_in <= {shift_in[5:0], sda_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                // shift_in holds the 7 address bits; sda_s is R/W.
                                if (shift_in == TARGET_ADDR) begin
                                    rw   <= sda_s;
                                    busy <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe   <= 1'b1;
                            ack_seen <= 1'b0;
                            state    <= ADDR_ACK;
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_rise) begin
                            ack_seen <= 1'b1;
                        end else if (scl_fall && ack_seen) begin
                            if (rw) begin
                                tx_req   <= 1'b1;
                                tx_shift <= tx_data[6:0];
                                sda_oe   <= ~tx_data[7];
                                bit_cnt  <= 4'd1;
                                state    <= RD_BYTE;
                            end else begin
                                sda_oe   <= 1'b0;
                                bit_cnt  <= 4'd0;
                                state    <= WR_BYTE;
                            end
                        end
                    end

                    WR_BYTE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_in <= {shift_in[5:0], sda_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data <= {shift_in, sda_s};
                                rx_load <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe   <= 1'b1;
                            ack_seen <= 1'b0;
                            state    <= WR_ACK;
                        end
                    end

                    WR_ACK: begin
                        if (scl_rise) begin
                            ack_seen <= 1'b1;
                        end else if (scl_fall && ack_seen) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WR_BYTE;
                        end
                    end

                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe   <= 1'b0;
                                ack_seen <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ack_seen <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall && ack_seen) begin
                            tx_req   <= 1'b1;
                            tx_shift <= tx_data[6:0];
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= 4'd1;
                            state    <= RD_BYTE;
                        end
                    end

                    WAIT_STOP: ;

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;
    logic       stop_det;
    wire        sda_w;

    pullup (sda_w);
    assign sda_w = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda_w),
        .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rw(rw), .busy(busy), .stop_det(stop_det)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor-owned counters and capture buffers.
    int         rxv_cnt = 0;
    int         txr_cnt = 0;
    int         stop_cnt = 0;
    int         tgt_low_cnt = 0;
    int         tx_idx = 0;
    logic [7:0] rx_got [0:63];

    // Bench-owned read data table and scoreboards.
    logic [7:0] tx_tab [0:7];
    logic [7:0] rx_exp [$];
    logic [7:0] rd_exp [$];
    int         rx_rd = 0;

    assign tx_data = tx_tab[tx_idx[2:0]];

    always @(negedge clk) begin
        if (!rst) begin
            if (!m_low && sda_w === 1'b0) tgt_low_cnt++;
            if (rx_valid) begin
                rx_got[rxv_cnt % 64] = rx_data;
                rxv_cnt++;
            end
            if (tx_req) begin
                txr_cnt++;
                tx_idx++;
            end
            if (stop_det) stop_cnt++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_bit(input logic drv, output logic smp);
        m_low = ~drv;
        wq();
        scl = 1'b1;
        wq();
        smp = sda_w;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic bus_start();
        m_low = 1'b1;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic bus_rstart();
        m_low = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        m_low = 1'b1;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        m_low = 1'b0;
        wq();
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] r);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            r[i] = s;
        end
        bus_bit(nack, s);
    endtask

    // Compare every rx_valid capture since the last drain against the scoreboard.
    task automatic drain_rx();
        while (rx_rd < rxv_cnt) begin
            if (rx_exp.size() > 0) check("rx_data", {24'd0, rx_got[rx_rd % 64]}, {24'd0, rx_exp.pop_front()});
            rx_rd++;
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       match;
    } wvec_t;

    wvec_t wv [6];

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         rx0, st0, low0, tr0;

        for (int i = 0; i < 8; i++) tx_tab[i] = 8'h00;

        wv[0] = '{8'hA0, 8'h3C, 1'b1};
        wv[1] = '{8'hA0, 8'h00, 1'b1};
        wv[2] = '{8'hA2, 8'hFF, 1'b0};
        wv[3] = '{8'h00, 8'h55, 1'b0};
        wv[4] = '{8'hA0, 8'hFF, 1'b1};
        wv[5] = '{8'hA1 ^ 8'h01, 8'hA5, 1'b1};

        repeat (4) @(posedge clk);
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stop_det", {31'd0, stop_det}, 32'd0);
        check("rst_sda", {31'd0, sda_w}, 32'd1);
        rst = 1'b0;
        wq();

        // Table-driven write transactions.
        for (int v = 0; v < 6; v++) begin
            rx0 = rxv_cnt; st0 = stop_cnt; low0 = tgt_low_cnt;
            bus_start();
            write_byte(wv[v].addr, ack);
            check($sformatf("v%0d_addr_ack", v), {31'd0, ack}, {31'd0, ~wv[v].match});
            check($sformatf("v%0d_busy", v), {31'd0, busy}, {31'd0, wv[v].match});
            if (wv[v].match) begin
                check($sformatf("v%0d_rw", v), {31'd0, rw}, 32'd0);
                rx_exp.push_back(wv[v].data);
            end
            write_byte(wv[v].data, ack);
            check($sformatf("v%0d_data_ack", v), {31'd0, ack}, {31'd0, ~wv[v].match});
            bus_stop();
            check($sformatf("v%0d_rx_pulses", v), rxv_cnt - rx0, wv[v].match ? 32'd1 : 32'd0);
            drain_rx();
            check($sformatf("v%0d_stop_det", v), stop_cnt - st0, 32'd1);
            check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
            if (!wv[v].match) check($sformatf("v%0d_no_drive", v), tgt_low_cnt - low0, 32'd0);
        end

        // Read two bytes: ACK the first, NACK the second.
        tx_tab[tx_idx[2:0]]         = 8'h96;
        tx_tab[(tx_idx + 1) % 8]    = 8'h5A;
        rd_exp.push_back(8'h96);
        rd_exp.push_back(8'h5A);
        tr0 = txr_cnt; st0 = stop_cnt;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        check("rd_rw", {31'd0, rw}, 32'd1);
        check("rd_busy", {31'd0, busy}, 32'd1);
        read_byte(1'b0, rb);
        check("rd_byte0", {24'd0, rb}, {24'd0, rd_exp.pop_front()});
        read_byte(1'b1, rb);
        check("rd_byte1", {24'd0, rb}, {24'd0, rd_exp.pop_front()});
        check("rd_busy_nack", {31'd0, busy}, 32'd0);
        bus_stop();
        check("rd_tx_req", txr_cnt - tr0, 32'd2);
        check("rd_stop_det", stop_cnt - st0, 32'd1);

        // Repeated START: write 0x11, then Sr and read one byte with NACK.
        tx_tab[tx_idx[2:0]] = 8'hC3;
        rd_exp.push_back(8'hC3);
        rx0 = rxv_cnt; tr0 = txr_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("sr_addr0_ack", {31'd0, ack}, 32'd0);
        check("sr_rw0", {31'd0, rw}, 32'd0);
        rx_exp.push_back(8'h11);
        write_byte(8'h11, ack);
        check("sr_data_ack", {31'd0, ack}, 32'd0);
        bus_rstart();
        write_byte(8'hA1, ack);
        check("sr_addr1_ack", {31'd0, ack}, 32'd0);
        check("sr_rw1", {31'd0, rw}, 32'd1);
        read_byte(1'b1, rb);
        check("sr_rd_byte", {24'd0, rb}, {24'd0, rd_exp.pop_front()});
        bus_stop();
        check("sr_rx_pulses", rxv_cnt - rx0, 32'd1);
        drain_rx();
        check("sr_tx_req", txr_cnt - tr0, 32'd1);

        // Aborted byte: four data bits then STOP.
        rx0 = rxv_cnt; st0 = stop_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("ab_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) bus_bit(i[0], ack);
        bus_stop();
        check("ab_no_rx", rxv_cnt - rx0, 32'd0);
        check("ab_stop_det", stop_cnt - st0, 32'd1);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_sda", {31'd0, sda_w}, 32'd1);
        rx0 = rxv_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("ab2_addr_ack", {31'd0, ack}, 32'd0);
        rx_exp.push_back(8'h77);
        write_byte(8'h77, ack);
        check("ab2_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        check("ab2_rx_pulses", rxv_cnt - rx0, 32'd1);
        drain_rx();

        // Reset while the target holds the address ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((8'hA0 >> i) & 8'h01) != 0, ack);
        m_low = 1'b0;
        wq();
        check("mr_ack_low", {31'd0, sda_w}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mr_sda_released", {31'd0, sda_w}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_rx_data", {24'd0, rx_data}, 32'd0);
        check("mr_rw", {31'd0, rw}, 32'd0);
        check("mr_tx_req", {31'd0, tx_req}, 32'd0);
        check("mr_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mr_stop_det", {31'd0, stop_det}, 32'd0);
        repeat (3) @(posedge clk);
        rst = 1'b0;
        bus_stop();
        rx0 = rxv_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("mr2_addr_ack", {31'd0, ack}, 32'd0);
        rx_exp.push_back(8'h42);
        write_byte(8'h42, ack);
        check("mr2_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        check("mr2_rx_pulses", rxv_cnt - rx0, 32'd1);
        drain_rx();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
